bk_subtractor_pipe: RTL and testbench

Pipelined 16-bit Brent-Kung subtractor with borrow-in/borrow-out and a valid/ready stream interface. It computes A − B − bin as A + ~B + ~bin on the same generate/propagate prefix tree as the team's combinational adder, split into three register stages. It sits between operand-sourcing logic and the result consumer in the arithmetic datapath, and sustains one operation per cycle with full backpressure.

---
 rtl/bk_pkg.sv | 20 ++
 rtl/bk_prefix_cell.sv | 12 +
 rtl/bk_subtractor_pipe.sv | 146 ++++++++++++++
 tb/tb_bk_subtractor_pipe.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared Brent-Kung definitions: widths, generate/propagate pair, combine rule.
package bk_pkg;

    localparam int unsigned BK_WIDTH  = 16;
    localparam int unsigned BK_LEVELS = 4;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Merge a higher-order group with the adjacent lower-order group.
    function automatic gp_t bk_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/bk_prefix_cell.sv
// Single prefix-tree node: combines a high and a low (G,P) group.
module bk_prefix_cell
    import bk_pkg::*;
(
    input  gp_t hi_i,
    input  gp_t lo_i,
    output gp_t gp_o
);

    assign gp_o = bk_combine(hi_i, lo_i);

endmodule

// File: rtl/bk_subtractor_pipe.sv
// Three-stage pipelined 16-bit Brent-Kung subtractor (A - B - bin) with a
// valid/ready stream interface and a single global stall.
// Optional macro BK_SUB_SATURATE_EN: signed-saturate diff on overflow.
module bk_subtractor_pipe
    import bk_pkg::*;
#(
    parameter int unsigned WIDTH = BK_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned W      = BK_WIDTH;
    localparam int unsigned S2_LVL = BK_LEVELS / 2;
    localparam int unsigned S3_NOD = BK_LEVELS - S2_LVL + BK_LEVELS - 1;

    logic advance;

    // Stage 1 registers
    gp_t [W-1:0] s1_gp_d, s1_gp_q;
    logic        s1_c0_q, s1_a15_q, s1_b15_q, s1_v_q;

    // Stage 2 registers
    gp_t [W-1:0]  s2_gp_q;
    logic [W-1:0] s2_p_q;
    logic         s2_c0_q, s2_a15_q, s2_b15_q, s2_v_q;

    // Prefix network wiring
    gp_t [W-1:0] u [0:S2_LVL];
    gp_t [W-1:0] t [0:S3_NOD];

    // Stage 3 results feeding the output registers
    logic [W:0]   carry;
    logic [W-1:0] raw_diff, diff_d;
    logic         bout_d, ovf_d;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Bitwise generate/propagate of a + ~b
    always_comb begin
        s1_gp_d = '0;
        for (int i = 0; i < int'(W); i++) begin
            s1_gp_d[i].g = a[i] & ~b[i];
            s1_gp_d[i].p = ~(a[i] ^ b[i]);
        end
    end

    // Up-sweep levels 1..2 between stage 1 and stage 2
    assign u[0] = s1_gp_q;
    for (genvar k = 1; k <= int'(S2_LVL); k++) begin : g_s2_lvl
        localparam int unsigned D = 1 << (k - 1);
        for (genvar i = 0; i < int'(W); i++) begin : g_bit
            if (((i + 1) % (2 * D)) == 0) begin : g_cell
                bk_prefix_cell u_cell (
                    .hi_i (u[k-1][i]),
                    .lo_i (u[k-1][i-D]),
                    .gp_o (u[k][i])
                );
            end else begin : g_pass
                assign u[k][i] = u[k-1][i];
            end
        end
    end

    // Up-sweep levels 3..4 then back-propagation spans 4, 2, 1 in stage 3
    assign t[0] = s2_gp_q;
    for (genvar j = 1; j <= int'(S3_NOD); j++) begin : g_s3_lvl
        localparam bit          UP = (j <= 2);
        localparam int unsigned D  = UP ? (4 << (j - 1)) : (8 >> (j - 2));
        for (genvar i = 0; i < int'(W); i++) begin : g_bit
            if (UP ? (((i + 1) % (2 * D)) == 0)
                   : ((((i + 1) % (2 * D)) == D) && (i >= 2 * D))) begin : g_cell
                bk_prefix_cell u_cell (
                    .hi_i (t[j-1][i]),
                    .lo_i (t[j-1][i-D]),
                    .gp_o (t[j][i])
                );
            end else begin : g_pass
                assign t[j][i] = t[j-1][i];
            end
        end
    end

    // Carries from full prefixes, then difference, borrow, overflow, saturation
    always_comb begin
        carry    = '0;
        carry[0] = s2_c0_q;
        for (int i = 0; i < int'(W); i++) begin
            carry[i+1] = t[S3_NOD][i].g | (t[S3_NOD][i].p & s2_c0_q);
        end
        raw_diff = s2_p_q ^ carry[W-1:0];
        bout_d   = ~carry[W];
        ovf_d    = (s2_a15_q != s2_b15_q) && (raw_diff[W-1] != s2_a15_q);
        diff_d   = raw_diff;
`ifdef BK_SUB_SATURATE_EN
        if (ovf_d) begin
            diff_d = s2_a15_q ? W'(16'h8000) : W'(16'h7FFF);
        end
`endif
    end

    // Pipeline registers: all stages shift together on advance
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (advance) begin
            s1_gp_q   <= s1_gp_d;
            s1_c0_q   <= ~bin;
            s1_a15_q  <= a[W-1];
            s1_b15_q  <= b[W-1];
            s1_v_q    <= in_valid;

            s2_gp_q   <= u[S2_LVL];
            for (int i = 0; i < int'(W); i++) begin
                s2_p_q[i] <= s1_gp_q[i].p;
            end
            s2_c0_q   <= s1_c0_q;
            s2_a15_q  <= s1_a15_q;
            s2_b15_q  <= s1_b15_q;
            s2_v_q    <= s1_v_q;

            out_valid <= s2_v_q;
            diff      <= diff_d;
            bout      <= bout_d;
            ovf       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bk_subtractor_pipe.sv
// Scoreboard bench for bk_subtractor_pipe: directed vectors, stall, reset, random.
module tb_bk_subtractor_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout, ovf;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_popped = 0;
    logic [17:0] sb [$];
    logic [17:0] last_out;
    logic [17:0] held;
    logic        hold_pend = 1'b0;
    logic        last_ov;
    logic        last_acc;

    always #5 clk = ~clk;

    bk_subtractor_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic bi);
        logic [16:0] full;
        logic [15:0] raw, d;
        logic        ov;
        full = {1'b0, x} - {1'b0, y} - 17'(bi);
        raw  = full[15:0];
        ov   = (x[15] != y[15]) && (raw[15] != x[15]);
        d    = raw;
`ifdef BK_SUB_SATURATE_EN
        if (ov) d = x[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {d, full[16], ov};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, sample just after, score transfers
    task automatic step(input logic iv, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tbin, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        a         = ta;
        b         = tb;
        bin       = tbin;
        out_ready = ordy;
        #1;
        last_ov  = out_valid;
        last_acc = in_valid && in_ready;
        if (hold_pend) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'({diff, bout, ovf}), 32'(held));
        end
        if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_out observed=%h expected=none", {diff, bout, ovf});
            end
            if (sb.size() > 0) begin
                last_out = {diff, bout, ovf};
                n_popped++;
                check("result", 32'(last_out), 32'(sb.pop_front()));
            end
        end
        if (last_acc) sb.push_back(model(ta, tb, tbin));
        hold_pend = out_valid && !out_ready;
        held      = {diff, bout, ovf};
    endtask

    // Single beat followed by three idle cycles; checks the 3-cycle latency
    task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                           input logic tbin, input logic [17:0] exp);
        logic [2:0] ovh;
        step(1'b1, ta, tb, tbin, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            ovh[2-i] = last_ov;
        end
        check({tag, "_latency"}, 32'(ovh), 32'b001);
        check(tag, 32'(last_out), 32'(exp));
    endtask

    initial begin
        logic [15:0] sa [6];
        logic [15:0] sbv [6];
        int          idx, cyc;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_outputs",   32'({diff, bout, ovf}), 32'd0);

        // Directed vectors
        run_one("tp_5m3",      16'h0005, 16'h0003, 1'b0, {16'h0002, 1'b0, 1'b0});
        run_one("tp_0m1",      16'h0000, 16'h0001, 1'b0, {16'hFFFF, 1'b1, 1'b0});
        run_one("tp_eq_bin",   16'h0010, 16'h0010, 1'b1, {16'hFFFF, 1'b1, 1'b0});
`ifdef BK_SUB_SATURATE_EN
        run_one("tp_ovf_neg",  16'h8000, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1});
        run_one("tp_ovf_pos",  16'h7FFF, 16'hFFFF, 1'b0, {16'h7FFF, 1'b1, 1'b1});
`else
        run_one("tp_ovf_neg",  16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b0, 1'b1});
        run_one("tp_ovf_pos",  16'h7FFF, 16'hFFFF, 1'b0, {16'h8000, 1'b1, 1'b1});
`endif

        // Six back-to-back beats with out_ready dropped for two cycles
        for (int i = 0; i < 6; i++) begin
            sa[i]  = 16'($urandom);
            sbv[i] = 16'($urandom);
        end
        n_popped = 0;
        idx = 0;
        cyc = 0;
        while ((idx < 6 || sb.size() > 0) && cyc < 40) begin
            if (idx < 6) step(1'b1, sa[idx], sbv[idx], idx[0], !(cyc == 4 || cyc == 5));
            else         step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            if (last_acc) idx++;
            cyc++;
        end
        check("stream_count", 32'(n_popped), 32'd6);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) step(1'b1, 16'h1234 + 16'(i), 16'h0101, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        sb.delete();
        hold_pend = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff",      32'(diff),      32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        n_popped = 0;
        repeat (6) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("midrst_no_ghosts", 32'(n_popped), 32'd0);

        // Random traffic with random valid and ready
        for (int i = 0; i < 10000; i++) begin
            step(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
                 ($urandom % 4) != 0);
        end
        cyc = 0;
        while (sb.size() > 0 && cyc < 20) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            cyc++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
